sbox_masked_driver: RTL and testbench

// Host-side driver for the 3-share (order-2) masked Skinny S-box core using HPC2 gadgets and clock gating.

---
 rtl/sbox_masked_driver.sv | 190 +++++++++++++++++++
 tb/tb_sbox_masked_driver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_masked_driver.sv
// sbox_masked_driver: host-side driver for a 3-share masked Skinny S-box core.
// Splits a plain nibble into Boolean shares, feeds fresh randomness, starts the
// core, waits for its Synch pulse, then recombines the output shares.
// Optional RUN-state watchdog: define SBOX_DRV_TIMEOUT_EN.
module sbox_masked_driver #(
  parameter int unsigned LATENCY = 5,
  parameter logic [31:0] SEED    = 32'h1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  dout,
  output logic        err,
  output logic [3:0]  X_s0,
  output logic [3:0]  X_s1,
  output logic [3:0]  X_s2,
  output logic [11:0] Fresh,
  output logic        sbox_rst,
  input  logic        Synch,
  input  logic [3:0]  Y_s0,
  input  logic [3:0]  Y_s1,
  input  logic [3:0]  Y_s2
);

  localparam int unsigned NW = 4;
  localparam int unsigned LW = 32;
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [LW-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lfsr_q, lfsr_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [NW-1:0] dout_q, dout_d;
  logic          err_q, err_d;
  logic [NW-1:0] x_s0_q, x_s0_d;
  logic [NW-1:0] x_s1_q, x_s1_d;
  logic [NW-1:0] x_s2_q, x_s2_d;
  logic          sbox_rst_q, sbox_rst_d;
  logic          accept_c;
  logic          timeout_c;

  assign accept_c = in_valid && in_ready_q;

`ifdef SBOX_DRV_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_c = (state_q == S_RUN) && !Synch && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog counter: counts cycles spent in RUN, cleared elsewhere
  always_comb begin
    cnt_d = '0;
    if (state_q == S_RUN) cnt_d = cnt_q + CNT_W'(1);
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Watchdog must outlast the core's nominal latency
  always_ff @(posedge clk) begin
    if (!rst) assert (TIMEOUT > LATENCY)
      else $error("sbox_masked_driver: TIMEOUT must exceed LATENCY");
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Parameter sanity: LFSR must not lock up at zero
  always_ff @(posedge clk) begin
    if (!rst) assert (SEED != '0 && LATENCY > 0 && TIMEOUT > 0)
      else $error("sbox_masked_driver: illegal parameter set");
  end

  // LFSR advance, one step per cycle
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      x_s0_q      <= '0;
      x_s1_q      <= '0;
      x_s2_q      <= '0;
      sbox_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      x_s0_q      <= x_s0_d;
      x_s1_q      <= x_s1_d;
      x_s2_q      <= x_s2_d;
      sbox_rst_q  <= sbox_rst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_c) state_d = S_RUN;
      S_RUN: begin
        if (Synch)          state_d = S_CAPT;
        else if (timeout_c) state_d = S_IDLE;
      end
      S_CAPT: state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; recombine XOR sits only on the CAPT path
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    err_d       = 1'b0;
    x_s0_d      = x_s0_q;
    x_s1_d      = x_s1_q;
    x_s2_d      = x_s2_q;
    sbox_rst_d  = sbox_rst_q;
    case (state_q)
      S_IDLE: begin
        sbox_rst_d = 1'b1;
        if (accept_c) begin
          x_s1_d     = lfsr_q[3:0];
          x_s2_d     = lfsr_q[7:4];
          x_s0_d     = din ^ lfsr_q[3:0] ^ lfsr_q[7:4];
          sbox_rst_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!Synch && timeout_c) begin
          err_d      = 1'b1;
          sbox_rst_d = 1'b1;
        end
      end
      S_CAPT: begin
        dout_d      = Y_s0 ^ Y_s1 ^ Y_s2;
        out_valid_d = 1'b1;
        sbox_rst_d  = 1'b1;
      end
      S_OUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
        sbox_rst_d  = 1'b1;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign err       = err_q;
  assign X_s0      = x_s0_q;
  assign X_s1      = x_s1_q;
  assign X_s2      = x_s2_q;
  assign sbox_rst  = sbox_rst_q;
  assign Fresh     = lfsr_q[19:8];

endmodule

// File: tb/tb_sbox_masked_driver.sv
// tb_sbox_masked_driver: scoreboard bench with a behavioural masked-core stub.
module tb_sbox_masked_driver;

  localparam int unsigned LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  din = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  dout;
  logic        err;
  logic [3:0]  X_s0, X_s1, X_s2;
  logic [11:0] Fresh;
  logic        sbox_rst;
  logic        synch_c;
  logic [3:0]  Y_s0, Y_s1, Y_s2;

  sbox_masked_driver #(.LATENCY(LAT), .SEED(32'h1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .err(err),
    .X_s0(X_s0), .X_s1(X_s1), .X_s2(X_s2), .Fresh(Fresh), .sbox_rst(sbox_rst),
    .Synch(synch_c), .Y_s0(Y_s0), .Y_s1(Y_s1), .Y_s2(Y_s2)
  );

  always #5 clk = ~clk;

  // Expected plain outputs for din = 0..F
  logic [3:0] exp_dout [16] = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                                4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};

  // Core stub: Synch LAT cycles after its reset drops, output freshly masked
  logic [63:0] sbox_lut = 64'hC6901A2B385D4E7F;
  int          ccnt = 0;
  bit          stub_en = 1'b1;
  bit          synch_inj = 1'b0;
  logic [3:0]  ym1 = 4'h0, ym2 = 4'h0;
  logic [3:0]  x_plain, y_plain;

  always @(posedge clk) begin
    if (sbox_rst)       ccnt <= 0;
    else if (ccnt < 63) ccnt <= ccnt + 1;
    ym1 <= 4'($urandom);
    ym2 <= 4'($urandom);
  end
  assign x_plain = X_s0 ^ X_s1 ^ X_s2;
  assign y_plain = sbox_lut[63 - 4*x_plain -: 4];
  assign Y_s1 = ym1;
  assign Y_s2 = ym2;
  assign Y_s0 = y_plain ^ ym1 ^ ym2;
  assign synch_c = (stub_en && !sbox_rst && ccnt == LAT - 1) || synch_inj;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: latency on rising out_valid, data on handshake, hold while stalled
  bit         prev_ov = 1'b0;
  logic [3:0] prev_dout = 4'h0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else                  check("latency", cyc - sb_q[0].cyc, LAT + 1);
      end
      if (out_valid && prev_ov) check("hold_dout", dout, prev_dout);
      if (out_valid && out_ready && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("dout", dout, e.data);
      end
      prev_ov   = out_valid;
      prev_dout = dout;
    end
  end

  logic [3:0] last_s1, last_s2;

  // Drive one nibble until accepted; optionally register the expected result
  task automatic send(input logic [3:0] d, input bit push, output int acc);
    int guard;
    guard = 0;
    acc   = -1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    din      = d;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc      = cyc;
      in_valid = 1'b0;
      if (push) sb_q.push_back('{exp_dout[d], acc});
      @(negedge clk);
      check("share_xor", X_s0 ^ X_s1 ^ X_s2, d);
      last_s1 = X_s1;
      last_s2 = X_s2;
    end
  endtask

  initial begin
    int acc, prev_acc, guard;
    bit bad, differ;
    logic [3:0] s1_first, s2_first;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_err", err, 0);
    check("rst_x_shares", {X_s0, X_s1, X_s2}, 0);
    check("rst_sbox_rst", sbox_rst, 1);
    check("rst_fresh", Fresh, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // First transaction: 0 -> C, latency checked by monitor
    send(4'h0, 1'b1, acc);
    repeat (10) @(negedge clk);
    check("sb_drained_first", sb_q.size(), 0);

    // Sweep 0..F back to back, out_ready high
    prev_acc = 0;
    differ   = 1'b0;
    s1_first = 4'h0;
    s2_first = 4'h0;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b1, acc);
      if (i == 0) begin
        s1_first = last_s1;
        s2_first = last_s2;
      end else begin
        check("throughput", acc - prev_acc, LAT + 3);
        if (last_s1 != s1_first || last_s2 != s2_first) differ = 1'b1;
      end
      prev_acc = acc;
    end
    repeat (12) @(negedge clk);
    check("sb_drained_sweep", sb_q.size(), 0);
    check("share_diversity", differ, 1);

    // Back-pressure: hold out_ready low for 10 cycles in OUT
    @(posedge clk); #1 out_ready = 1'b0;
    send(4'ha, 1'b1, acc);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("stall_out_valid_seen", out_valid, 1);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready || !out_valid) bad = 1'b1;
    end
    check("stall_hold", bad, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("sb_drained_stall", sb_q.size(), 0);

    // Reset 3 cycles after accept: result is discarded
    send(4'h3, 1'b1, acc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_low", in_ready, 0);
    check("abort_sbox_rst", sbox_rst, 1);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    check("abort_in_ready_high", in_ready, 1);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("abort_no_output", bad, 0);

    // Synch injected in IDLE is ignored
    @(posedge clk); #1 synch_inj = 1'b1;
    @(posedge clk); #1 synch_inj = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!in_ready || out_valid) bad = 1'b1;
    end
    check("idle_synch_ignored", bad, 0);

    // Core that never answers
    stub_en = 1'b0;
    send(4'h7, 1'b0, acc);
`ifdef SBOX_DRV_TIMEOUT_EN
    guard = 0;
    while (!err && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("timeout_err_seen", err, 1);
    check("timeout_err_time", cyc - acc, 16);
    check("timeout_in_ready", in_ready, 1);
    check("timeout_sbox_rst", sbox_rst, 1);
    @(negedge clk);
    check("timeout_err_pulse", err, 0);
    stub_en = 1'b1;
`else
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (err || in_ready || out_valid) bad = 1'b1;
    end
    check("no_timeout_stays_run", bad, 0);
    stub_en = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Recovery after the stalled-core scenario
    send(4'h9, 1'b1, acc);
    repeat (10) @(negedge clk);
    check("sb_drained_final", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
